// File: rtl/frame_draw_scheduler.sv
// Frame-rate tick generator plus a lowest-index-first arbiter that time-shares the single
// VGA pixel-write port among the background, dino, obstacle and score drawers.
module frame_draw_scheduler #(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int FPS             = 60,
  parameter int WATCHDOG        = 65535
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        pause,
  input  logic [3:0]  req,
  input  logic [3:0]  done,
  input  logic [31:0] req_x,
  input  logic [27:0] req_y,
  input  logic [11:0] req_colour,
  input  logic [3:0]  req_plot,
  output logic [3:0]  grant,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        frame_tick,
  output logic        busy,
  output logic        overrun,
  output logic        timeout,
  output logic [15:0] frame_count
);

  localparam int TICK_DIV = CLOCK_FREQUENCY / FPS;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW       = $clog2(WATCHDOG + 1);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WD_LIMIT    = WW'(WATCHDOG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    pending_q, pending_d;
  logic [3:0]    grant_q, grant_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          tick;

  function automatic logic [3:0] lowest_set(input logic [3:0] v);
    lowest_set = v & (~v + 4'd1);
  endfunction

  // Frame divider: only counts while the game is running and not paused.
  always_comb begin
    tick       = 1'b0;
    tick_cnt_d = tick_cnt_q;
    if (enable && !pause) begin
      if (tick_cnt_q == '0) begin
        tick       = 1'b1;
        tick_cnt_d = TICK_RELOAD;
      end else begin
        tick_cnt_d = tick_cnt_q - 1'b1;
      end
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // Arbitration sequence for one frame; a tick that lands mid-frame is dropped.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    grant_d       = grant_q;
    wd_d          = wd_q;
    overrun_d     = overrun_q | (tick & (state_q != IDLE));
    timeout_d     = timeout_q;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          pending_d = req;
          state_d   = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        if (!enable) begin
          pending_d = 4'd0;
          grant_d   = 4'd0;
          state_d   = IDLE;
        end else if (pending_q == 4'd0) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = IDLE;
        end else begin
          grant_d = lowest_set(pending_q);
          wd_d    = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        wd_d = wd_q + 1'b1;
        if (!enable) begin
          pending_d = 4'd0;
          grant_d   = 4'd0;
          state_d   = IDLE;
        end else if ((done & grant_q) != 4'd0) begin
          pending_d = pending_q & ~grant_q;
          grant_d   = 4'd0;
          state_d   = ARB;
        end else if (wd_d == WD_LIMIT) begin
          // A stuck drawer loses the port but the frame still finishes and counts.
          pending_d = pending_q & ~grant_q;
          grant_d   = 4'd0;
          timeout_d = 1'b1;
          state_d   = ARB;
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        pending_d = 4'd0;
        grant_d   = 4'd0;
        state_d   = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      tick_cnt_q    <= TICK_RELOAD;
      pending_q     <= 4'd0;
      grant_q       <= 4'd0;
      wd_q          <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      wd_q          <= wd_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Pixel port mux: grant is one-hot, so an AND-OR select gives zeros when nobody owns it.
  always_comb begin
    x      = 8'd0;
    y      = 7'd0;
    colour = 3'd0;
    plot   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x      = x | (req_x[8*i +: 8] & {8{grant_q[i]}});
      y      = y | (req_y[7*i +: 7] & {7{grant_q[i]}});
      colour = colour | (req_colour[3*i +: 3] & {3{grant_q[i]}});
      plot   = plot | (req_plot[i] & grant_q[i]);
    end
  end

  assign grant       = grant_q;
  assign frame_tick  = tick;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
- Sequences per-frame redraw of the game screen by sharing the single VGA pixel-write port among four sprite requesters: 0 = background erase, 1 = dino, 2 = obstacle, 3 = score.
- Generates the frame tick from the system clock and grants the write port to one requester at a time, lowest index first.
- Runs only while the game FSM is in its game or jump states; the tick freezes while the FSM is in pause.

Parameters:
- CLOCK_FREQUENCY, 25000000, system clock in Hz.
- FPS, 60, frame rate; TICK_DIV = CLOCK_FREQUENCY/FPS (integer division).
- WATCHDOG, 65535, maximum grant length in cycles before a forced release.

Ports:
- Clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- enable  in  1  high while the game FSM asserts ld_game or calc_jump.
- pause  in  1  the game FSM's ld_pause.
- req  in  4  per-requester draw request, level.
- done  in  4  per-requester completion pulse; sampled only for the granted requester.
- req_x  in  32  four 8-bit x coordinates; requester i at bits [8i+7:8i].
- req_y  in  28  four 7-bit y coordinates, packed the same way.
- req_colour  in  12  four 3-bit colours, packed the same way.
- req_plot  in  4  per-requester pixel write strobe.
- grant  out  4  one-hot write-port grant, registered.
- x  out  8  muxed pixel x.
- y  out  7  muxed pixel y.
- colour  out  3  muxed pixel colour.
- plot  out  1  muxed write strobe.
- frame_tick  out  1  one-cycle pulse per frame.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky; a tick arrived while busy.
- timeout  out  1  sticky; the watchdog fired.
- frame_count  out  16  number of completed frames, wraps at 65535 -> 0.

Behaviour:
- Reset values: all outputs 0; state IDLE; tick counter = TICK_DIV-1; pending = 0; watchdog = 0.
- Tick counter:
  - Decrements only when enable=1 and pause=0; otherwise holds its value.
  - At 0, frame_tick=1 for that cycle and the counter reloads to TICK_DIV-1.
  - Result: first tick occurs TICK_DIV enabled cycles after reset.
- States: IDLE, ARB, GRANT.
- IDLE:
  - On frame_tick: pending <= req (snapshot); go to ARB.
  - Requests raised after the snapshot wait for the next frame.
- ARB:
  - If pending==0: frame_count++ and go to IDLE.
  - Else: grant <= one-hot of the lowest set pending bit; watchdog <= 0; go to GRANT.
  - Latency: tick at cycle t -> grant visible at t+2.
- GRANT:
  - If done[g]=1 for the granted index g: clear pending[g], grant <= 0, go to ARB.
  - Minimum one idle (ARB) cycle occurs between consecutive grants.
  - done bits of non-granted requesters are ignored; bits outside the snapshot are never granted.
- Watchdog:
  - Increments every GRANT cycle.
  - On reaching WATCHDOG: timeout <= 1; treated as done[g] (pending[g] cleared, go to ARB).
  - The frame still completes and counts.
- Output mux:
  - x, y, colour, plot come combinationally from the granted requester's fields.
  - plot = req_plot[g] & grant[g].
  - With no grant: x, y, colour, plot = 0.
- frame_tick while busy: overrun <= 1 and the tick is dropped; the counter still reloads and no new snapshot is taken.
- enable falling while busy:
  - Next cycle returns to IDLE with grant=0 and pending=0.
  - frame_count is not incremented.
  - The tick counter holds its value and does not reload.
- pause=1 mid-frame: the current frame sequence completes normally; only tick generation stops.
- Simultaneous done[g] and watchdog expiry: treated as a normal done; timeout is not set.
- overrun and timeout clear only on reset.
- reset asserted mid-grant: grant drops asynchronously and all state returns to reset values.

Test Plan:
- Tick period:
  - Stimulus: CLOCK_FREQUENCY=1000, FPS=10, enable=1, req=0.
  - Required: frame_tick pulses at cycles 100, 200, 300; frame_count = 1, 2, 3 two cycles after each tick.
- Ordering and handshake:
  - Stimulus: req=4'b1011; each requester pulses done 5 cycles after its grant.
  - Required: grant sequence 0001, 0010, 1000, each 6 cycles long, separated by one zero cycle; frame_count +1 after the last grant.
- Mux:
  - Stimulus: while requester 1 is granted, req_x[15:8]=8'd40, req_y[13:7]=7'd106, req_colour[5:3]=3'd5, req_plot[1]=1; requester 0 drives all fields to 0xFF.
  - Required: x=40, y=106, colour=5, plot=1.
- Watchdog:
  - Stimulus: WATCHDOG=16; req=4'b0100; done is never asserted.
  - Required: grant=0100 for 16 cycles, then timeout=1, grant=0, frame completes.
- Overrun and pause:
  - Overrun stimulus: hold a grant longer than TICK_DIV. Required: overrun=1, no second snapshot, frame_count increments only once.
  - Pause stimulus: pause=1 for 50 cycles. Required: next tick delayed by exactly 50 cycles.
- Abort and reset:
  - Stimulus: drop enable mid-grant.
  - Required: grant=0 and busy=0 next cycle, frame_count unchanged.
  - Stimulus: assert reset asynchronously mid-grant.
  - Required: all outputs 0 before the next Clock edge.
